// File: rtl/compare_sequencer.sv
// compare_sequencer: pops song/reference FIFO words in lockstep, hands each pair to
// the pitch comparison engine with a start pulse, waits for score_ready and counts
// scored pairs into frames. Sticky flags report FIFO skew and engine timeouts.
// Optional feature: define ZERO_SKIP_EN to skip pairs whose reference word is 0
// (reference rest), counting them in skip_count instead of scoring them.
module compare_sequencer #(
   parameter int unsigned FREQ_W    = 15,
   parameter int unsigned FRAME_LEN = 256,
   parameter int unsigned CNT_W     = 12,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              clear_err,
   input  logic              song_empty,
   input  logic              ref_empty,
   input  logic              song_valid,
   input  logic              ref_valid,
   input  logic [FREQ_W-1:0] song_dout,
   input  logic [FREQ_W-1:0] ref_dout,
   output logic              rd_en,
   output logic              cmp_start,
   output logic [FREQ_W-1:0] cmp_sung_freq,
   output logic [FREQ_W-1:0] cmp_ref_freq,
   input  logic              score_ready,
   output logic [CNT_W-1:0]  pair_count,
   output logic [CNT_W-1:0]  skip_count,
   output logic              frame_done,
   output logic              busy,
   output logic              skew_err,
   output logic              timeout_err
);

   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT_VALID,
      START,
      WAIT_SCORE
   } state_t;

   state_t            state;
   logic              wait_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [CNT_W-1:0]  pair_next;

   // incremented pair count, compared against the frame length on success
   assign pair_next = pair_count + CNT_W'(1);

`ifndef ZERO_SKIP_EN
   assign skip_count = '0;
`endif

   // sequencing FSM with registered strobes, counters, latched data and error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         wait_cnt      <= 1'b0;
         to_cnt        <= '0;
         rd_en         <= 1'b0;
         cmp_start     <= 1'b0;
         cmp_sung_freq <= '0;
         cmp_ref_freq  <= '0;
         pair_count    <= '0;
`ifdef ZERO_SKIP_EN
         skip_count    <= '0;
`endif
         frame_done    <= 1'b0;
         busy          <= 1'b0;
         skew_err      <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         rd_en      <= 1'b0;
         cmp_start  <= 1'b0;
         frame_done <= 1'b0;
         // clear first so that an error set later in this cycle takes priority
         if (clear_err) begin
            skew_err    <= 1'b0;
            timeout_err <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (enable && !song_empty && !ref_empty) begin
                  rd_en <= 1'b1;
                  busy  <= 1'b1;
                  state <= READ;
               end
            end
            READ: begin
               wait_cnt <= 1'b0;
               state    <= WAIT_VALID;
            end
            WAIT_VALID: begin
               if (song_valid && ref_valid) begin
                  cmp_sung_freq <= song_dout;
                  cmp_ref_freq  <= ref_dout;
`ifdef ZERO_SKIP_EN
                  if (ref_dout == '0) begin
                     if (skip_count != '1)
                        skip_count <= skip_count + CNT_W'(1);
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     cmp_start <= 1'b1;
                     state     <= START;
                  end
`else
                  cmp_start <= 1'b1;
                  state     <= START;
`endif
               end else if (song_valid ^ ref_valid) begin
                  skew_err <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else if (wait_cnt) begin
                  skew_err <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  wait_cnt <= 1'b1;
               end
            end
            START: begin
               to_cnt <= '0;
               state  <= WAIT_SCORE;
            end
            WAIT_SCORE: begin
               // success takes priority over a timeout expiring in the same cycle
               if (score_ready) begin
                  if (pair_next == CNT_W'(FRAME_LEN)) begin
                     pair_count <= '0;
                     frame_done <= 1'b1;
                  end else begin
                     pair_count <= pair_next;
                  end
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
